inst_sequencer: RTL

//  Instruction register and timing sequencer for the 6502 core. Counterpart of the instruction decoder:
//  - consumes the decoder's icyc/rcyc/scyc/sinst strobes;
//  - produces the inst[7:0] and cycle[2:0] pair that the decoder consumes.

---
 rtl/inst_sequencer_if.sv | 31 +++
 rtl/inst_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/inst_sequencer_if.sv
// Handshake and data bundle between the 6502 instruction decoder and the
// instruction sequencer. The decoder side (master) drives the timing strobes,
// bus and interrupt inputs; the sequencer side (slave) returns opcode/T-state.
interface inst_sequencer_if;
  logic [7:0] databus;   // opcode source on rcyc
  logic       icyc;      // advance cycle counter
  logic       rcyc;      // end of instruction
  logic       scyc;      // stall
  logic       sinst;     // interrupt sequence accepted
  logic       irq_in;    // maskable request, level
  logic       nmi_in;    // non-maskable request, rising edge
  logic       irq_dis;   // status I flag
  logic [7:0] inst;      // current opcode
  logic [2:0] cycle;     // current T-state
  logic       rst;       // pending reset request
  logic       nmi;       // pending NMI
  logic       irq;       // unmasked pending IRQ
  logic       sync;      // cycle == 0
  logic       seq_err;   // sticky sequencing error
  logic       wdt_trip;  // watchdog expiry pulse

  modport master (
    output databus, icyc, rcyc, scyc, sinst, irq_in, nmi_in, irq_dis,
    input  inst, cycle, rst, nmi, irq, sync, seq_err, wdt_trip
  );

  modport slave (
    input  databus, icyc, rcyc, scyc, sinst, irq_in, nmi_in, irq_dis,
    output inst, cycle, rst, nmi, irq, sync, seq_err, wdt_trip
  );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction register and T-state sequencer for the 6502 core; latches and prioritises reset/NMI/IRQ.
// Latency: all state registered, a strobe takes effect at the next clk edge (irq/sync decode registered state).
// Backpressure: scyc stalls inst/cycle while interrupt latches and NMI edge detector keep updating.
// Ports: clk, clr (sync active-high reset), bus (inst_sequencer_if.slave).
// Optional feature: define SEQ_WATCHDOG_EN to add a watchdog that forces a reset sequence after
// WDT_LIMIT non-stalled cycles without rcyc; otherwise wdt_trip is tied low.
module inst_sequencer #(
  parameter logic [7:0] INT_OPCODE = 8'h00,
  parameter int         WDT_LIMIT  = 16
) (
  input  logic             clk,
  input  logic             clr,
  inst_sequencer_if.slave  bus
);

  logic [7:0] inst_q,     inst_d;
  logic [2:0] cycle_q,    cycle_d;
  logic       rst_q,      rst_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       irq_pend_q, irq_pend_d;
  logic       nmi_hist_q, nmi_hist_d;
  logic       seq_err_q,  seq_err_d;

  logic nmi_edge;
  logic int_req;
  logic sinst_ok;

`ifdef SEQ_WATCHDOG_EN
  localparam int WDT_CNT_W = $clog2(WDT_LIMIT + 1);
  logic [WDT_CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                 wdt_trip_q, wdt_trip_d;
`endif

  assign nmi_edge = bus.nmi_in & ~nmi_hist_q;
  // Interrupt service is requested from the registered pending state, so a
  // request that arrives on the same edge as rcyc is serviced one instruction later.
  assign int_req  = rst_q | nmi_pend_q | (irq_pend_q & ~bus.irq_dis);
  // Retirement is only meaningful at T0 of the forced interrupt opcode.
  assign sinst_ok = bus.sinst && (inst_q == INT_OPCODE) && (cycle_q == 3'd0);

  always_comb begin
    inst_d     = inst_q;
    cycle_d    = cycle_q;
    rst_d      = rst_q;
    nmi_pend_d = nmi_pend_q;
    irq_pend_d = bus.irq_in;
    nmi_hist_d = bus.nmi_in;
    seq_err_d  = seq_err_q;

    if (sinst_ok) begin
      if (rst_q) rst_d      = 1'b0;
      else       nmi_pend_d = 1'b0;
    end
    // A fresh edge beats a same-cycle retirement so the new NMI is not lost.
    if (nmi_edge) nmi_pend_d = 1'b1;

    if (!bus.scyc) begin
      if (bus.rcyc) begin
        cycle_d = 3'd0;
        inst_d  = int_req ? INT_OPCODE : bus.databus;
      end else if (bus.icyc) begin
        // Running past T7 means the decoder lost track of the instruction.
        if (cycle_q == 3'd7) seq_err_d = 1'b1;
        cycle_d = cycle_q + 3'd1;
      end
    end

`ifdef SEQ_WATCHDOG_EN
    wdt_cnt_d  = wdt_cnt_q;
    wdt_trip_d = 1'b0;
    if (!bus.scyc) begin
      if (bus.rcyc) begin
        wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_CNT_W'(WDT_LIMIT - 1)) begin
        // Hung sequence: restart through the reset vector.
        wdt_cnt_d  = '0;
        wdt_trip_d = 1'b1;
        cycle_d    = 3'd0;
        inst_d     = INT_OPCODE;
        rst_d      = 1'b1;
        seq_err_d  = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inst_q     <= INT_OPCODE;
      cycle_q    <= 3'd0;
      rst_q      <= 1'b1;
      nmi_pend_q <= 1'b0;
      irq_pend_q <= 1'b0;
      nmi_hist_q <= 1'b0;
      seq_err_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdt_cnt_q  <= '0;
      wdt_trip_q <= 1'b0;
`endif
    end else begin
      inst_q     <= inst_d;
      cycle_q    <= cycle_d;
      rst_q      <= rst_d;
      nmi_pend_q <= nmi_pend_d;
      irq_pend_q <= irq_pend_d;
      nmi_hist_q <= nmi_hist_d;
      seq_err_q  <= seq_err_d;
`ifdef SEQ_WATCHDOG_EN
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_trip_q <= wdt_trip_d;
`endif
    end
  end

  assign bus.inst    = inst_q;
  assign bus.cycle   = cycle_q;
  assign bus.rst     = rst_q;
  assign bus.nmi     = nmi_pend_q;
  assign bus.irq     = irq_pend_q & ~bus.irq_dis;
  assign bus.sync    = (cycle_q == 3'd0);
  assign bus.seq_err = seq_err_q;
`ifdef SEQ_WATCHDOG_EN
  assign bus.wdt_trip = wdt_trip_q;
`else
  assign bus.wdt_trip = 1'b0;
`endif

endmodule
